// File: rtl/doodle_motion_if.sv
// Game-state and button inputs plus position outputs of the doodle motion block.
// The master side is the game controller; the slave side is doodle_motion.
interface doodle_motion_if;
    logic       q_I;
    logic       q_Up;
    logic       q_Down;
    logic       q_Done;
    logic       BtnL;
    logic       BtnR;
    logic [9:0] object_x;
    logic [9:0] object_y;
    logic [9:0] up_count;
    logic       tick;

    modport master (
        output q_I, q_Up, q_Down, q_Done, BtnL, BtnR,
        input  object_x, object_y, up_count, tick
    );

    modport slave (
        input  q_I, q_Up, q_Down, q_Done, BtnL, BtnR,
        output object_x, object_y, up_count, tick
    );
endinterface

// File: rtl/doodle_motion.sv
// Doodle position tracker: a free-running tick divider paces vertical jump/fall
// motion and button-driven horizontal motion, clamped to the playfield.
module doodle_motion #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned X_START  = 449,
    parameter int unsigned Y_START  = 480,
    parameter int unsigned STEP_X   = 2,
    parameter int unsigned H_MIN    = 144,
    parameter int unsigned H_MAX    = 754,
    parameter int unsigned V_TOP    = 35
) (
    input logic            Clk,
    input logic            Reset,
    doodle_motion_if.slave dm
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        MODE_IDLE,
        MODE_UP,
        MODE_DOWN,
        MODE_DONE,
        MODE_INVALID
    } mode_t;

    mode_t         mode;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic          up_prev;
    logic          up_entry;
    logic [9:0]    pos_x;
    logic [9:0]    pos_y;
    logic [9:0]    up_cnt;

    logic [10:0] x_w;
    logic [10:0] x_left;
    logic [10:0] x_right;
    logic [10:0] x_step;
    logic [10:0] y_w;
    logic [10:0] y_rise;
    logic [10:0] y_fall;
    logic [10:0] up_w;
    logic [10:0] up_inc;

    always_comb begin
        mode = MODE_INVALID;
        case ({dm.q_I, dm.q_Up, dm.q_Down, dm.q_Done})
            4'b1000: mode = MODE_IDLE;
            4'b0100: mode = MODE_UP;
            4'b0010: mode = MODE_DOWN;
            4'b0001: mode = MODE_DONE;
            default: mode = MODE_INVALID;
        endcase
    end

    // Entry is detected on the raw q_Up so a glitch through an invalid code
    // does not fake a fresh jump.
    assign up_entry = (mode == MODE_UP) && !up_prev;

    always_comb begin
        x_w  = {1'b0, pos_x};
        y_w  = {1'b0, pos_y};
        up_w = {1'b0, up_cnt};

        // Compare before subtracting so the left move never wraps below zero.
        if (x_w < 11'(H_MIN) + 11'(STEP_X))
            x_left = 11'(H_MIN);
        else
            x_left = x_w - 11'(STEP_X);

        x_right = x_w + 11'(STEP_X);
        if (x_right > 11'(H_MAX))
            x_right = 11'(H_MAX);

        x_step = x_w;
        case ({dm.BtnL, dm.BtnR})
            2'b10:   x_step = x_left;
            2'b01:   x_step = x_right;
            default: x_step = x_w;
        endcase

        y_rise = (y_w <= 11'(V_TOP)) ? y_w : y_w - 11'd1;
        y_fall = (y_w >= 11'd1023)   ? y_w : y_w + 11'd1;
        up_inc = (up_w >= 11'd1023)  ? up_w : up_w + 11'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            up_prev <= 1'b0;
            pos_x   <= 10'(X_START);
            pos_y   <= 10'(Y_START);
            up_cnt  <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == DIV_LAST);
            up_prev <= dm.q_Up;

            case (mode)
                MODE_IDLE: begin
                    pos_x  <= 10'(X_START);
                    pos_y  <= 10'(Y_START);
                    up_cnt <= '0;
                end
                MODE_UP: begin
                    if (tick) begin
                        pos_x <= x_step[9:0];
                        pos_y <= y_rise[9:0];
                    end
                    if (up_entry)
                        up_cnt <= '0;
                    else if (tick)
                        up_cnt <= up_inc[9:0];
                end
                MODE_DOWN: begin
                    if (tick) begin
                        pos_x <= x_step[9:0];
                        pos_y <= y_fall[9:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm.object_x = pos_x;
    assign dm.object_y = pos_y;
    assign dm.up_count = up_cnt;
    assign dm.tick     = tick;
endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion with a 4-cycle motion tick.
module tb_doodle_motion;
    localparam int unsigned TDIV = 4;

    logic Clk;
    logic Reset;
    int   tests;
    int   fails;

    doodle_motion_if dm ();

    doodle_motion #(.TICK_DIV(TDIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dm    (dm.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int up);
        check({tag, "_x"},  {1'b0, dm.object_x}, 11'(x));
        check({tag, "_y"},  {1'b0, dm.object_y}, 11'(y));
        check({tag, "_up"}, {1'b0, dm.up_count}, 11'(up));
    endtask

    // Each iteration waits (bounded) for a tick cycle, then steps past its update edge.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            while (dm.tick !== 1'b1 && guard < 3 * int'(TDIV)) begin
                @(negedge Clk);
                guard++;
            end
            if (dm.tick !== 1'b1) begin
                check("tick_wait", {10'd0, dm.tick}, 11'd1);
                return;
            end
            @(negedge Clk);
        end
    endtask

    task automatic set_state(input logic i, input logic u, input logic d, input logic f);
        dm.q_I    = i;
        dm.q_Up   = u;
        dm.q_Down = d;
        dm.q_Done = f;
    endtask

    task automatic pulse_reset(input string tag);
        Reset = 1'b1;
        #1;
        check_pos(tag, 449, 480, 0);
        check({tag, "_tick"}, {10'd0, dm.tick}, 11'd0);
        @(negedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        Reset    = 1'b1;
        dm.BtnL  = 1'b0;
        dm.BtnR  = 1'b0;
        set_state(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset and idle: tick every 4th cycle, position parked.
        repeat (3) @(negedge Clk);
        check_pos("reset", 449, 480, 0);
        check("reset_tick", {10'd0, dm.tick}, 11'd0);
        Reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            check($sformatf("idle_tick_%0d", i), {10'd0, dm.tick}, ((i % 4) == 0) ? 11'd1 : 11'd0);
        end
        check_pos("idle", 449, 480, 0);
        run_ticks(1);

        // Rise 10 ticks, then fall 5.
        set_state(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(10);
        check_pos("up10", 449, 470, 10);
        set_state(1'b0, 1'b0, 1'b1, 1'b0);
        run_ticks(5);
        check_pos("down5", 449, 475, 10);

        // Re-enter UP on a tick cycle: count clears, y still moves.
        for (int g = 0; g < 3 * int'(TDIV) && dm.tick !== 1'b1; g++) @(negedge Clk);
        check("reentry_tick_seen", {10'd0, dm.tick}, 11'd1);
        set_state(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        check_pos("reentry", 449, 474, 0);
        run_ticks(1);
        check_pos("reentry_next", 449, 473, 1);

        // Right edge clamp, then both buttons.
        dm.BtnR = 1'b1;
        run_ticks(152);
        check_pos("right_753", 753, 321, 153);
        run_ticks(1);
        check_pos("right_754", 754, 320, 154);
        run_ticks(2);
        check_pos("right_hold", 754, 318, 156);
        dm.BtnL = 1'b1;
        run_ticks(2);
        check_pos("both_btn", 754, 316, 158);

        // Reset mid-jump; first tick arrives 4 cycles after release.
        dm.BtnR = 1'b0;
        pulse_reset("rst_midup1");
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            check($sformatf("post_rst_tick_%0d", i), {10'd0, dm.tick}, (i == 4) ? 11'd1 : 11'd0);
        end

        // Left edge clamp.
        run_ticks(152);
        check_pos("left_145", 145, 328, 152);
        run_ticks(1);
        check_pos("left_144", 144, 327, 153);
        run_ticks(2);
        check_pos("left_hold", 144, 325, 155);

        // Top clamp: count keeps rising while y sticks at V_TOP.
        dm.BtnL = 1'b0;
        run_ticks(289);
        check_pos("top_36", 144, 36, 444);
        run_ticks(3);
        check_pos("top_hold", 144, 35, 447);

        // DONE freezes everything even with a button held.
        dm.BtnR = 1'b1;
        set_state(1'b0, 1'b0, 1'b0, 1'b1);
        run_ticks(8);
        check_pos("done", 144, 35, 447);

        // Fresh UP entry from DONE, then reset mid-UP.
        dm.BtnR = 1'b0;
        set_state(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(2);
        check_pos("up_after_done", 144, 35, 2);
        pulse_reset("rst_midup2");
        set_state(1'b0, 1'b0, 1'b1, 1'b0);
        Reset = 1'b0;
        run_ticks(3);
        check_pos("down_after_rst", 449, 483, 0);

        // Invalid encodings hold outputs while ticks continue.
        dm.BtnL = 1'b1;
        set_state(1'b0, 1'b1, 1'b1, 1'b0);
        run_ticks(8);
        check_pos("invalid_11", 449, 483, 0);
        set_state(1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(2);
        check_pos("invalid_00", 449, 483, 0);

        // Idle reloads the start position without waiting for a tick.
        dm.BtnL = 1'b0;
        set_state(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check_pos("idle_reload", 449, 480, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/doodle_motion.md
DOODLE_MOTION -- requirements
Module: doodle_motion

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 500000, giving Clk cycles per motion step; legal range is 2..2^20.
REQ-002 The block SHALL have parameter X_START, default 449, giving the reset and idle doodle x position in pixels.
REQ-003 The block SHALL have parameter Y_START, default 480, giving the reset and idle doodle y position in pixels.
REQ-004 The block SHALL have parameter STEP_X, default 2, giving horizontal pixels moved per tick.
REQ-005 The block SHALL have parameter H_MIN, default 144, giving the leftmost legal object_x.
REQ-006 The block SHALL have parameter H_MAX, default 754, giving the rightmost legal object_x.
REQ-007 The block SHALL have parameter V_TOP, default 35, giving the smallest legal object_y.
REQ-008 Port Clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-009 Port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-010 Ports q_I, q_Up, q_Down, q_Done, input, 1 bit each: one-hot game state from the game state machine.
REQ-011 Port BtnL, input, 1 bit: move-left request, already synchronised and debounced.
REQ-012 Port BtnR, input, 1 bit: move-right request, already synchronised and debounced.
REQ-013 Port object_x, output, 10 bits, registered: doodle x position.
REQ-014 Port object_y, output, 10 bits, registered: doodle y position.
REQ-015 Port up_count, output, 10 bits, registered: pixels risen in the current jump.
REQ-016 Port tick, output, 1 bit, registered: one-cycle motion-step strobe.

Function
REQ-017 The tick divider counter SHALL count 0..TICK_DIV-1 and wrap to 0, running continuously in every game state.
REQ-018 tick SHALL be 1 for exactly the one cycle after the counter equals TICK_DIV-1, giving one pulse per TICK_DIV cycles.
REQ-019 While q_I=1 (valid one-hot), the block SHALL load object_x=X_START, object_y=Y_START and up_count=0 every cycle, regardless of tick.
REQ-020 The block SHALL register the previous-cycle q_Up; a cycle with q_Up=1 and previous q_Up=0 is an UP entry.
REQ-021 On an UP entry cycle, the block SHALL load up_count=0; this overrides any tick increment in that cycle.
REQ-022 In UP on a tick, object_y SHALL decrement by 1, but hold at V_TOP if already at or below V_TOP.
REQ-023 In UP on a tick (not an entry cycle), up_count SHALL increment by 1, saturating at 1023; it SHALL still increment when object_y is clamped at V_TOP.
REQ-024 In DOWN on a tick, object_y SHALL increment by 1, saturating at 1023; up_count SHALL be held.
REQ-025 In UP or DOWN on a tick, horizontal motion SHALL follow the buttons:
 - BtnL=1, BtnR=0: object_x = max(object_x-STEP_X, H_MIN), with no unsigned underflow.
 - BtnR=1, BtnL=0: object_x = min(object_x+STEP_X, H_MAX).
 - both or neither: object_x held.
REQ-026 In DONE, object_x, object_y and up_count SHALL be held; the final position remains visible.
REQ-027 If the state inputs are not one-hot (zero or several asserted), the block SHALL hold all position outputs and keep the divider running.
REQ-028 Between ticks, all position outputs SHALL be held, except the loads in REQ-019 and REQ-021.
REQ-029 All arithmetic SHALL use 11-bit intermediates so clamping and saturation are exact.

Reset
REQ-030 While Reset=1, the block SHALL immediately force: divider=0, tick=0, object_x=X_START, object_y=Y_START, up_count=0, previous q_Up=0.
REQ-031 Reset asserted mid-jump SHALL abort motion with no partial update; after release, the first tick occurs TICK_DIV cycles later.

Verification (bench uses TICK_DIV=4)
REQ-032 Reset then idle 20 cycles with q_I=1 -> tick is high every 4th cycle, object_x=449, object_y=480, up_count=0.
REQ-033 q_Up for 10 ticks from Y_START -> object_y=470 and up_count=10; on switch to q_Down for 5 ticks -> object_y=475 and up_count stays 10.
REQ-034 DOWN->UP re-entry coinciding with a tick -> up_count=0 that cycle and object_y decrements; the next tick gives up_count=1.
REQ-035 BtnL held in UP with object_x=145 -> object_x=144 and holds at 144; BtnR held with object_x=753 -> object_x=754 and holds; both buttons pressed -> object_x unchanged.
REQ-036 UP with object_y=36 for 3 ticks -> object_y=35 and holds, up_count rises by 3; q_Done for 8 ticks -> all outputs frozen.
REQ-037 Reset pulse mid-UP, then q_Up=0, q_Down=1 and an invalid state {q_Up,q_Down}=11 for 8 ticks -> after the reset pulse, outputs return to their reset values; during the invalid state, outputs are unchanged and tick continues.
